instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 33 +++
 rtl/instr_loader_if.sv | 45 ++++
 rtl/instr_loader_word_assembler.sv | 58 +++++
 rtl/instr_loader.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// ---------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the instruction loader slice: default instruction
// memory size, bus widths, the loader state encoding and a helper that sizes
// the word-index counter from the memory size.
// ---------------------------------------------------------------------------
package instr_loader_pkg;

    // Instruction memory size in bytes (power of two, greater than 4).
    localparam int MEM_SIZE_DEFAULT = 1024;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 32;
    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } load_state_e;

    // Bits needed to index every 32-bit word of a memory of mem_size bytes.
    function automatic int idx_width(input int mem_size);
        int w;
        w = $clog2(mem_size) - 2;
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// ---------------------------------------------------------------------------
// instr_loader_if
// Byte-stream input and instruction-memory write bus of the loader.
//
//   byte_valid / byte_data / byte_ready : program byte stream
//   wr_en / wr_addr / wr_data           : instruction-memory write port
//
// Handshake: a byte moves on a rising clk edge where byte_valid and
// byte_ready are both 1. The producer may raise or drop byte_valid at any
// time; byte_ready does not depend on byte_valid. wr_en is a one-cycle
// strobe with no back-pressure; wr_addr/wr_data are meaningful only while
// wr_en is 1.
//
// master : the loader (consumes bytes, drives the write port)
// slave  : the environment (produces bytes, observes the write port)
// ---------------------------------------------------------------------------
interface instr_loader_if;
    import instr_loader_pkg::*;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/instr_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Collects four bytes into one little-endian 32-bit word: byte k of a word
// ends up in bits [8k+7:8k].
//
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   clear_i      : restart at byte 0 with an empty word (has priority)
//   byte_en_i    : a byte is accepted this cycle
//   byte_i       : the accepted byte
//   word_o       : the completed word, valid in the cycle last_byte_o is 1
//   last_byte_o  : the byte accepted this cycle completes a word
// ---------------------------------------------------------------------------
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              last_byte_o
);

    logic [DATA_W-1:0] word_q, word_d;
    logic [1:0]        idx_q, idx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            idx_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear_i) begin
            word_d = '0;
            idx_d  = 2'd0;
        end else if (byte_en_i) begin
            // Shift in from the top: after four bytes the first one sits
            // in the lowest lane, giving little-endian order.
            word_d = {byte_i, word_q[DATA_W-1:8]};
            idx_d  = idx_q + 2'd1;
        end
    end

    // The completing byte is forwarded directly so the caller can capture
    // the whole word in the same cycle it is accepted.
    assign word_o      = {byte_i, word_q[DATA_W-1:8]};
    assign last_byte_o = byte_en_i && (idx_q == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
// Loads a program from a byte stream into instruction memory, one 32-bit
// little-endian word at a time, starting at byte address 0.
//
// Ports:
//   clk        : clock
//   reset      : asynchronous active-low reset
//   start      : one-cycle pulse starting a load (ignored unless idle)
//   num_words  : words to load, sampled with start
//   bus        : byte stream in, memory write port out (master side)
//   busy       : a load is in progress
//   done       : one-cycle pulse when a load completes
//   error      : sticky, set when a start asks for more words than fit in
//                memory; cleared by the next accepted start
//   dbg_state  : current FSM state
//
// Each word takes 4 RECV cycles plus 1 WRITE cycle at full rate; wr_en is
// raised the cycle after the 4th byte of a word is accepted.
// ---------------------------------------------------------------------------
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_words,
    instr_loader_if.master     bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output load_state_e        dbg_state
);

    localparam int IDX_W     = idx_width(MEM_SIZE);
    localparam int MAX_WORDS = MEM_SIZE / 4;

    load_state_e        state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic               error_q, error_d;

    logic               byte_accept;
    logic               asm_clear;
    logic               asm_last;
    logic [DATA_W-1:0]  asm_word;
    logic               too_many;
    logic               last_word;

    assign byte_accept = (state_q == RECV) && bus.byte_valid;
    assign too_many    = {16'd0, num_words} > 32'(MAX_WORDS);
    // Compare in 32 bits so count_q - 1 cannot wrap against the index.
    assign last_word   = ({16'd0, count_q} - 32'd1) == 32'(idx_q);
    // Any start taken in IDLE discards a partial word left by an aborted load.
    assign asm_clear   = (state_q == IDLE) && start;

    word_assembler u_word_assembler (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (asm_clear),
        .byte_en_i   (byte_accept),
        .byte_i      (bus.byte_data),
        .word_o      (asm_word),
        .last_byte_o (asm_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        error_d = error_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        // Empty load: complete immediately, nothing written.
                        state_d = DONE;
                        error_d = 1'b0;
                    end else if (too_many) begin
                        // Rejected: stay idle and flag it.
                        error_d = 1'b1;
                    end else begin
                        state_d = RECV;
                        count_d = num_words;
                        idx_d   = '0;
                        error_d = 1'b0;
                    end
                end
            end
            RECV: begin
                if (asm_last) begin
                    state_d = WRITE;
                    data_d  = asm_word;
                    addr_d  = {{(ADDR_W-IDX_W-2){1'b0}}, idx_q, 2'b00};
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.byte_ready = (state_q == RECV);
    assign bus.wr_en      = (state_q == WRITE);
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = data_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign error          = error_q;
    assign dbg_state      = state_q;

endmodule
